// File: rtl/pacman_dir_ctrl.sv
// Button synchronizer/debouncer, one-hot direction latch and
// frame-aligned move strobe feeding the Pac-Man movement datapath.
module pacman_dir_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int V_ACTIVE        = 480,
  parameter int MOVE_PERIOD     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic [9:0] vCount,
  input  logic       game_active,
  input  logic       ack,
  output logic [3:0] dir_req,
  output logic       dir_valid,
  output logic       frame_tick,
  output logic       move_tick
);

  localparam int MW = $clog2(MOVE_PERIOD) + 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [MW-1:0]    MV_LAST = MW'(MOVE_PERIOD - 1);
  localparam logic [9:0]       V_ACT   = 10'(V_ACTIVE);

  logic [3:0] btn;
  logic [3:0] s1_q, s2_q;
  logic [3:0] db_q, db_d;
  logic [3:0] pd_q, press_q;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0] dir_q, dir_d;
  logic       vld_q, vld_d;
  logic [9:0] vprev_q;
  logic       ft_q, ft_d;
  logic       mt_q, mt_d;
  logic [MW-1:0] mcnt_q, mcnt_d;

  assign btn = {btn_up, btn_down, btn_left, btn_right};

  // A level must disagree for DEBOUNCE_CYCLES straight cycles to flip.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          db_d[i] = ~db_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    dir_d = dir_q;
    vld_d = vld_q;
    if (ack) begin
      dir_d = '0;
      vld_d = 1'b0;
    end else if (|press_q) begin
      vld_d = 1'b1;
      if (press_q[3])      dir_d = 4'b1000;
      else if (press_q[2]) dir_d = 4'b0100;
      else if (press_q[1]) dir_d = 4'b0010;
      else                 dir_d = 4'b0001;
    end
  end

  always_comb begin
    ft_d   = (vCount == V_ACT) && (vprev_q != V_ACT);
    mt_d   = 1'b0;
    mcnt_d = mcnt_q;
    if (!game_active) begin
      mcnt_d = '0;
    end else if (ft_d) begin
      if (mcnt_q == MV_LAST) begin
        mt_d   = 1'b1;
        mcnt_d = '0;
      end else begin
        mcnt_d = mcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      db_q    <= '0;
      cnt_q   <= '0;
      pd_q    <= '0;
      press_q <= '0;
      dir_q   <= '0;
      vld_q   <= 1'b0;
      vprev_q <= '0;
      ft_q    <= 1'b0;
      mt_q    <= 1'b0;
      mcnt_q  <= '0;
    end else begin
      s1_q    <= btn;
      s2_q    <= s1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      pd_q    <= db_q;
      press_q <= db_q & ~pd_q;
      dir_q   <= dir_d;
      vld_q   <= vld_d;
      vprev_q <= vCount;
      ft_q    <= ft_d;
      mt_q    <= mt_d;
      mcnt_q  <= mcnt_d;
    end
  end

  assign dir_req    = dir_q;
  assign dir_valid  = vld_q;
  assign frame_tick = ft_q;
  assign move_tick  = mt_q;

endmodule
